// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional stall/bubble performance counters are enabled by defining MEM2WB_PERF_CNT_EN.
module mem_wb_skid_reg #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [WORD_W-1:0] in_alu_res,
    input  logic [WORD_W-1:0] in_mem_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic [ADDR_W-1:0] out_dest,
    output logic [WORD_W-1:0] out_alu_res,
    output logic [WORD_W-1:0] out_mem_rd,
    output logic [WORD_W-1:0] out_wb_val,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic [ADDR_W-1:0] dest;
        logic [WORD_W-1:0] alu_res;
        logic [WORD_W-1:0] mem_rd;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t entry_in_s;
    logic   in_ready_q;
    logic   out_valid_s;
    logic   accept_s;
    logic   consume_s;

    assign entry_in_s = '{wb_en: in_wb_en, mem_r_en: in_mem_r_en, dest: in_dest,
                          alu_res: in_alu_res, mem_rd: in_mem_rd};
    assign out_valid_s = (state_q != S_EMPTY);
    assign accept_s    = in_valid & in_ready_q;
    assign consume_s   = out_valid_s & out_ready;

    // State, storage and registered ready; ready reflects the skid slot being free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    // Next-state and storage update; flush drops everything, data is left untouched.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept_s) begin
                        state_d = S_ONE;
                        main_d  = entry_in_s;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
                S_ONE: begin
                    if (accept_s && consume_s) begin
                        main_d = entry_in_s;
                    end else if (accept_s) begin
                        state_d = S_FULL;
                        skid_d  = entry_in_s;
                    end else if (consume_s) begin
                        state_d = S_EMPTY;
                    end else begin
                        state_d = S_ONE;
                    end
                end
                S_FULL: begin
                    if (consume_s) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = S_FULL;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // Output decode from the main entry; wb_en is gated so a bubble never writes.
    always_comb begin
        in_ready     = in_ready_q;
        out_valid    = out_valid_s;
        out_wb_en    = main_q.wb_en & out_valid_s;
        out_mem_r_en = main_q.mem_r_en;
        out_dest     = main_q.dest;
        out_alu_res  = main_q.alu_res;
        out_mem_rd   = main_q.mem_rd;
        if (main_q.mem_r_en) begin
            out_wb_val = main_q.mem_rd;
        end else begin
            out_wb_val = main_q.alu_res;
        end
    end

`ifdef MEM2WB_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating stall/bubble counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid_s && !out_ready && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (!out_valid_s && (bubble_q != CNT_MAX)) begin
                bubble_q <= bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Randomized + directed bench for mem_wb_skid_reg against a queue-based reference model.
module tb_mem_wb_skid_reg;

`ifdef MEM2WB_PERF_CNT_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_wb_en = 1'b0;
    logic        in_mem_r_en = 1'b0;
    logic [3:0]  in_dest = 4'd0;
    logic [31:0] in_alu_res = 32'd0;
    logic [31:0] in_mem_rd = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_wb_en;
    logic        out_mem_r_en;
    logic [3:0]  out_dest;
    logic [31:0] out_alu_res;
    logic [31:0] out_mem_rd;
    logic [31:0] out_wb_val;
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] bubble_cnt;

    mem_wb_skid_reg #(.WORD_W(32), .ADDR_W(4), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_dest(in_dest),
        .in_alu_res(in_alu_res), .in_mem_rd(in_mem_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_dest(out_dest),
        .out_alu_res(out_alu_res), .out_mem_rd(out_mem_rd), .out_wb_val(out_wb_val),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        wb;
        bit        mr;
        bit [3:0]  dest;
        bit [31:0] alu;
        bit [31:0] rd;
    } ent_t;

    ent_t q[$];
    bit   m_ready = 1'b1;
    int   m_stall = 0;
    int   m_bubble = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt_max = (1 << TB_CNT_W) - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        chk("out_wb_en", {63'd0, out_wb_en}, {63'd0, (q.size() > 0) && q[0].wb});
        if (q.size() > 0) begin
            chk("out_mem_r_en", {63'd0, out_mem_r_en}, {63'd0, q[0].mr});
            chk("out_dest", {60'd0, out_dest}, {60'd0, q[0].dest});
            chk("out_alu_res", {32'd0, out_alu_res}, {32'd0, q[0].alu});
            chk("out_mem_rd", {32'd0, out_mem_rd}, {32'd0, q[0].rd});
            chk("out_wb_val", {32'd0, out_wb_val}, {32'd0, q[0].mr ? q[0].rd : q[0].alu});
        end
`ifdef MEM2WB_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`else
        chk("stall_cnt", 64'(stall_cnt), 64'd0);
        chk("bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_wb_en"}, {63'd0, out_wb_en}, 64'd0);
        chk({tag, "_mem_r_en"}, {63'd0, out_mem_r_en}, 64'd0);
        chk({tag, "_dest"}, {60'd0, out_dest}, 64'd0);
        chk({tag, "_alu"}, {32'd0, out_alu_res}, 64'd0);
        chk({tag, "_rd"}, {32'd0, out_mem_rd}, 64'd0);
        chk({tag, "_wb_val"}, {32'd0, out_wb_val}, 64'd0);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
    endtask

    // One clock: inputs are already stable; advance the model across the edge and compare.
    task automatic tick(output bit accepted);
        bit   acc;
        bit   con;
        ent_t e;
        acc = in_valid && m_ready;
        con = (q.size() > 0) && out_ready;
        e.wb = in_wb_en; e.mr = in_mem_r_en; e.dest = in_dest;
        e.alu = in_alu_res; e.rd = in_mem_rd;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_ready = 1'b1;
            m_stall = 0;
            m_bubble = 0;
        end else begin
            if (q.size() > 0 && !out_ready && m_stall < cnt_max) m_stall++;
            if (q.size() == 0 && m_bubble < cnt_max) m_bubble++;
            if (flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            m_ready = (q.size() < 2);
        end
        accepted = acc && !flush && !rst;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input bit wb, input bit mr, input bit [3:0] d,
                          input bit [31:0] alu, input bit [31:0] rd);
        in_valid = v; in_wb_en = wb; in_mem_r_en = mr; in_dest = d;
        in_alu_res = alu; in_mem_rd = rd;
    endtask

    initial begin
        bit a;
        @(negedge clk);
        rst = 1'b1;
        tick(a);
        tick(a);
        rst = 1'b0;
        check_all_zero("rst");
        repeat (3) tick(a);
`ifdef MEM2WB_PERF_CNT_EN
        chk("idle_bubble3", 64'(bubble_cnt), 64'd3);
`endif

        // streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 4'(i), 32'(i * 16), 32'hDEAD_0000);
            tick(a);
            chk("stream_dest", {60'd0, out_dest}, 64'(i));
        end
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        tick(a);

        // backpressure into FULL, then drain
        out_ready = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 4'd2, 32'hA, 32'd0);
        tick(a);
        set_in(1'b1, 1'b1, 1'b0, 4'd3, 32'hB, 32'd0);
        tick(a);
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) tick(a);
        out_ready = 1'b1;
        tick(a);
        chk("drain_b", {60'd0, out_dest}, 64'd3);
        tick(a);

        // load select
        set_in(1'b1, 1'b1, 1'b1, 4'd5, 32'h100, 32'hCAFE);
        tick(a);
        chk("ld_sel_mem", {32'd0, out_wb_val}, 64'hCAFE);
        set_in(1'b1, 1'b1, 1'b0, 4'd5, 32'h100, 32'hCAFE);
        tick(a);
        chk("ld_sel_alu", {32'd0, out_wb_val}, 64'h100);
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        tick(a);

        // flush in FULL with a new input presented
        out_ready = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 4'd6, 32'h6, 32'd0);
        tick(a);
        set_in(1'b1, 1'b1, 1'b0, 4'd7, 32'h7, 32'd0);
        tick(a);
        flush = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 4'hF, 32'hF, 32'd0);
        tick(a);
        flush = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_wb_en", {63'd0, out_wb_en}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        out_ready = 1'b1;
        repeat (2) tick(a);

        // reset in FULL together with flush and in_valid
        out_ready = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 4'd8, 32'h8, 32'h88);
        tick(a);
        set_in(1'b1, 1'b1, 1'b1, 4'd9, 32'h9, 32'h99);
        tick(a);
        rst = 1'b1;
        flush = 1'b1;
        tick(a);
        rst = 1'b0;
        flush = 1'b0;
        check_all_zero("rst_full");

        // stall counter saturation
        set_in(1'b1, 1'b1, 1'b0, 4'd1, 32'h1, 32'd0);
        tick(a);
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (5) tick(a);
`ifdef MEM2WB_PERF_CNT_EN
        chk("stall_sat", 64'(stall_cnt), 64'd3);
`endif
        out_ready = 1'b1;
        tick(a);

        // randomized traffic with protocol-compliant holding of unaccepted inputs
        a = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || a) begin
                set_in($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                       4'($urandom), $urandom, $urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 150) == 0);
            tick(a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
